// File: rtl/jt12_presc_if.sv
// jt12_presc_if: CPU write interface decoding prescaler selects, forwarding register writes and modelling busy.
// Optional JT12_PRESC_SYNC_EN adds a 2-flop input synchroniser for asynchronous CPU buses.
module jt12_presc_if #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       set_n6,
  output logic       set_n3,
  output logic       set_n2,
  output logic [8:0] reg_addr,
  output logic [7:0] reg_din,
  output logic       reg_wr
);
  localparam logic [11:0] BUS_IDLE = 12'hC00;
  logic [11:0] bus_in, bus_q;
  logic        strobe, strobe_prev, ev, accept, addr_ev, part;
  logic [7:0]  cnt, cnt_nxt, addr_lat;
  logic [2:0]  set_q, set_nxt;
  assign bus_in = {cs_n, wr_n, addr, din};
`ifdef JT12_PRESC_SYNC_EN
  logic [11:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= BUS_IDLE;
      sync2 <= BUS_IDLE;
      bus_q <= BUS_IDLE;
    end else begin
      sync1 <= bus_in;
      sync2 <= sync1;
      bus_q <= sync2;
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus_q <= BUS_IDLE;
    else bus_q <= bus_in;
`endif
  assign strobe  = ~bus_q[11] & ~bus_q[10];
  assign ev      = strobe & ~strobe_prev;
  assign accept  = ev & bus_q[8] & ~busy;
  assign addr_ev = ev & ~bus_q[8];
  // set_q is {n6, n3, n2}; only part-0 writes to 0x2D..0x2F move it
  always_comb begin
    cnt_nxt = accept ? 8'(BUSY_CYCLES) : cnt - {7'd0, |cnt};
    set_nxt = (!accept || part) ? set_q :
              addr_lat == 8'h2D ? 3'b100 :
              addr_lat == 8'h2E ? 3'b010 :
              addr_lat == 8'h2F ? 3'b001 : set_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      strobe_prev <= 1'b0;
      cnt         <= 8'd0;
      busy        <= 1'b0;
      reg_wr      <= 1'b0;
      reg_addr    <= 9'd0;
      reg_din     <= 8'd0;
      addr_lat    <= 8'd0;
      part        <= 1'b0;
      set_q       <= 3'b100;
    end else begin
      strobe_prev <= strobe;
      cnt         <= cnt_nxt;
      busy        <= cnt_nxt != 8'd0;
      reg_wr      <= accept;
      set_q       <= set_nxt;
      if (addr_ev) begin
        addr_lat <= bus_q[7:0];
        part     <= bus_q[9];
      end
      if (accept) begin
        reg_addr <= {part, addr_lat};
        reg_din  <= bus_q[7:0];
      end
    end
  assign {set_n6, set_n3, set_n2} = set_q;
  assign dout = {busy, 7'd0};
endmodule

// File: tb/tb_jt12_presc_if.sv
// tb_jt12_presc_if: scoreboard bench for jt12_presc_if; event latency follows JT12_PRESC_SYNC_EN.
module tb_jt12_presc_if;
`ifdef JT12_PRESC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, wr_n = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout, reg_din;
  logic       busy, set_n6, set_n3, set_n2, reg_wr;
  logic [8:0] reg_addr;
  logic [2:0] set_v;
  logic [16:0] exp_q[$];
  logic [16:0] exp_e;
  int errors = 0, checks = 0, pulses = 0;
  assign set_v = {set_n6, set_n3, set_n2};
  always #5 clk = ~clk;
  jt12_presc_if #(.BUSY_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .set_n6(set_n6), .set_n3(set_n3), .set_n2(set_n2),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_wr(reg_wr)
  );
  // scoreboard: every reg_wr pulse must match the oldest expected write
  always @(negedge clk)
    if (rst_n && reg_wr) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_reg_wr: got addr=%h din=%h, required no pulse", reg_addr, reg_din);
      end else begin
        exp_e = exp_q.pop_front();
        if ({reg_addr, reg_din} !== exp_e) begin
          errors++;
          $display("FAIL reg_write: got addr=%h din=%h, required addr=%h din=%h",
                   reg_addr, reg_din, exp_e[16:8], exp_e[7:0]);
        end
      end
    end
  task automatic bus(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    repeat (hold) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n); end
  endtask
  task automatic test_reset();
    int p0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (set_v !== 3'b100) begin errors++; $display("FAIL reset_set: got %b, required 100", set_v); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h, required 00", dout); end
    if (reg_addr !== 9'h000) begin errors++; $display("FAIL reset_reg_addr: got %h, required 000", reg_addr); end
    if (reg_din !== 8'h00) begin errors++; $display("FAIL reset_reg_din: got %h, required 00", reg_din); end
    rst_n = 1'b1;
    p0 = pulses;
    repeat (20) @(negedge clk);
    checks += 2;
    if (pulses !== p0) begin errors++; $display("FAIL reset_idle_pulses: got %0d, required %0d", pulses, p0); end
    if (set_v !== 3'b100 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle_state: got set=%b busy=%b, required 100/0", set_v, busy); end
  endtask
  task automatic test_prescaler();
    int n = 0;
    bus(2'b00, 8'h2E, 1);
    exp_q.push_back({9'h02E, 8'h00});
    bus(2'b01, 8'h00, 1);
    repeat (LAT) @(negedge clk);
    checks += 4;
    if (reg_wr !== 1'b1) begin errors++; $display("FAIL presc_reg_wr: got %b, required 1", reg_wr); end
    if (set_v !== 3'b010) begin errors++; $display("FAIL presc_set_2e: got %b, required 010", set_v); end
    if (dout !== 8'h80) begin errors++; $display("FAIL presc_dout: got %h, required 80", dout); end
    if (reg_addr !== 9'h02E) begin errors++; $display("FAIL presc_reg_addr: got %h, required 02E", reg_addr); end
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (reg_wr !== 1'b0) begin errors++; $display("FAIL presc_pulse_width: got reg_wr=%b, required 0", reg_wr); end
      end
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL presc_busy_len: got %0d, required 32", n); end
  endtask
  task automatic test_dropped();
    int n;
    bus(2'b00, 8'h2F, 1);
    exp_q.push_back({9'h02F, 8'h55});
    bus(2'b01, 8'h55, 1);
    repeat (LAT) @(negedge clk);
    repeat (8) @(negedge clk);
    bus(2'b01, 8'hAA, 1);
    n = 10;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks += 3;
    if (n != 32) begin errors++; $display("FAIL drop_busy_len: got %0d, required 32", n); end
    if (reg_din !== 8'h55) begin errors++; $display("FAIL drop_reg_din: got %h, required 55", reg_din); end
    if (set_v !== 3'b001) begin errors++; $display("FAIL drop_set_2f: got %b, required 001", set_v); end
  endtask
  task automatic test_part1();
    wait_idle();
    bus(2'b10, 8'h2D, 1);
    exp_q.push_back({9'h12D, 8'h77});
    bus(2'b11, 8'h77, 1);
    repeat (LAT) @(negedge clk);
    checks += 3;
    if (reg_wr !== 1'b1) begin errors++; $display("FAIL part1_reg_wr: got %b, required 1", reg_wr); end
    if (reg_addr !== 9'h12D) begin errors++; $display("FAIL part1_reg_addr: got %h, required 12D", reg_addr); end
    if (set_v !== 3'b001) begin errors++; $display("FAIL part1_set: got %b, required 001", set_v); end
  endtask
  task automatic test_busy_edge();
    wait_idle();
    bus(2'b00, 8'h2E, 1);
    exp_q.push_back({9'h02E, 8'h01});
    bus(2'b01, 8'h01, 1);
    repeat (LAT) @(negedge clk);
    repeat (30 - LAT) @(negedge clk);
    bus(2'b01, 8'h99, 1);
    repeat (LAT) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL edge_busy_fall: got %b, required 0", busy); end
    if (reg_din !== 8'h01) begin errors++; $display("FAIL edge_last_busy_drop: got %h, required 01", reg_din); end
    exp_q.push_back({9'h02E, 8'h02});
    bus(2'b01, 8'h02, 1);
    repeat (LAT) @(negedge clk);
    repeat (31 - LAT) @(negedge clk);
    exp_q.push_back({9'h02E, 8'h03});
    bus(2'b01, 8'h03, 1);
    repeat (LAT) @(negedge clk);
    checks += 2;
    if (reg_wr !== 1'b1) begin errors++; $display("FAIL edge_first_idle_accept: got %b, required 1", reg_wr); end
    if (reg_din !== 8'h03) begin errors++; $display("FAIL edge_first_idle_din: got %h, required 03", reg_din); end
    repeat (30 - LAT) @(negedge clk);
    bus(2'b00, 8'h2F, 1);
    exp_q.push_back({9'h02F, 8'h04});
    bus(2'b01, 8'h04, 1);
    repeat (LAT) @(negedge clk);
    checks += 2;
    if (reg_addr !== 9'h02F) begin errors++; $display("FAIL edge_addr_at_fall: got %h, required 02F", reg_addr); end
    if (set_v !== 3'b001) begin errors++; $display("FAIL edge_addr_set: got %b, required 001", set_v); end
  endtask
  task automatic test_hold();
    int k, p0;
    wait_idle();
    bus(2'b00, 8'h2D, 1);
    p0 = pulses;
    exp_q.push_back({9'h02D, 8'h11});
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h11;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (reg_wr) break;
    end
    checks++;
    if (k != LAT + 1) begin errors++; $display("FAIL hold_latency: got %0d, required %0d", k, LAT + 1); end
    repeat (100 - k) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (50) @(negedge clk);
    checks += 2;
    if (pulses != p0 + 1) begin errors++; $display("FAIL hold_pulses: got %0d, required %0d", pulses - p0, 1); end
    if (set_v !== 3'b100) begin errors++; $display("FAIL hold_set_2d: got %b, required 100", set_v); end
  endtask
  task automatic test_reset_mid_busy();
    int p0;
    wait_idle();
    bus(2'b00, 8'h2F, 1);
    exp_q.push_back({9'h02F, 8'h12});
    bus(2'b01, 8'h12, 1);
    repeat (LAT + 3) @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b, required 1", busy); end
    if (set_v !== 3'b001) begin errors++; $display("FAIL rst_mid_pre_set: got %b, required 001", set_v); end
    bus(2'b00, 8'h2E, 1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h34;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    if (set_v !== 3'b100) begin errors++; $display("FAIL rst_mid_set: got %b, required 100", set_v); end
    if (reg_wr !== 1'b0 || reg_addr !== 9'h000) begin errors++; $display("FAIL rst_mid_regs: got wr=%b addr=%h, required 0/000", reg_wr, reg_addr); end
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (40) @(negedge clk);
    checks++;
    if (pulses != p0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d, required 0", pulses - p0); end
  endtask
  initial begin
    test_reset();
    test_prescaler();
    test_dropped();
    test_part1();
    test_busy_edge();
    test_hold();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_reg_wr: got %0d outstanding, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
